// File: rtl/ct_down_timer.sv
// Loadable mm:ss countdown timer that decrements on a 1 Hz tick strobe and pulses expire at 00:00.
// Optional CT_DOWN_TIMER_AUTO_RELOAD_EN: reload the last loaded value at expiry and keep running.
module ct_down_timer #(
    parameter int SEC_N = 60,
    parameter int MIN_N = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clr,
    input  logic       load,
    input  logic [6:0] ld_min,
    input  logic [6:0] ld_sec,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic       running,
    output logic       done,
    output logic       expire
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    localparam logic [6:0] SEC_MAX = 7'(SEC_N - 1);
    localparam logic [6:0] MIN_MAX = 7'(MIN_N - 1);

    state_t     state_q;
    logic [6:0] min_q, sec_q;
    logic       expire_q;
    logic [6:0] ld_min_c, ld_sec_c;
    logic       cnt_zero, cnt_one;

    assign ld_sec_c = (int'(ld_sec) >= SEC_N) ? SEC_MAX : ld_sec;
    assign ld_min_c = (int'(ld_min) >= MIN_N) ? MIN_MAX : ld_min;
    assign cnt_zero = (min_q == 7'd0) && (sec_q == 7'd0);
    // The tick seen at 00:01 is the one that expires; 00:00 itself is never decremented.
    assign cnt_one  = (min_q == 7'd0) && (sec_q == 7'd1);

`ifdef CT_DOWN_TIMER_AUTO_RELOAD_EN
    logic [13:0] reload_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            min_q    <= 7'd0;
            sec_q    <= 7'd0;
            expire_q <= 1'b0;
`ifdef CT_DOWN_TIMER_AUTO_RELOAD_EN
            reload_q <= 14'd0;
`endif
        end else begin
            expire_q <= 1'b0;
            if (clr) begin
                state_q <= S_IDLE;
                min_q   <= 7'd0;
                sec_q   <= 7'd0;
`ifdef CT_DOWN_TIMER_AUTO_RELOAD_EN
                reload_q <= 14'd0;
`endif
            end else if (load && state_q != S_RUN) begin
                state_q <= S_IDLE;
                min_q   <= ld_min_c;
                sec_q   <= ld_sec_c;
`ifdef CT_DOWN_TIMER_AUTO_RELOAD_EN
                reload_q <= {ld_min_c, ld_sec_c};
`endif
            end else begin
                case (state_q)
                    S_IDLE, S_PAUSED: begin
                        if (start && !cnt_zero) state_q <= S_RUN;
                    end
                    S_RUN: begin
                        // pause wins over start and swallows a coincident tick
                        if (pause) begin
                            state_q <= S_PAUSED;
                        end else if (tick) begin
                            if (cnt_one) begin
                                expire_q <= 1'b1;
`ifdef CT_DOWN_TIMER_AUTO_RELOAD_EN
                                {min_q, sec_q} <= reload_q;
`else
                                sec_q   <= 7'd0;
                                state_q <= S_EXPIRED;
`endif
                            end else if (sec_q != 7'd0) begin
                                sec_q <= sec_q - 7'd1;
                            end else begin
                                sec_q <= SEC_MAX;
                                min_q <= min_q - 7'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign min_out = min_q;
    assign sec_out = sec_q;
    assign expire  = expire_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_EXPIRED);
endmodule

// File: doc/ct_down_timer.md
Name: ct_down_timer

Overview:
- Loadable mm:ss countdown timer; the count-down counterpart of the team's mod-N up counters.
- Decrements on a one-cycle-wide 1 Hz enable strobe (tick) from the seconds prescaler.
- Signals expiry to the alarm/buzzer control logic.
- Holds seconds (mod SEC_N) and minutes (mod MIN_N) with borrow from seconds into minutes, under a four-state control FSM.

Parameters:
SEC_N, 60, seconds modulus; sec_out range 0..SEC_N-1
MIN_N, 60, minutes modulus; min_out range 0..MIN_N-1

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
tick  in  1  1 Hz enable strobe, one clk cycle wide
clr  in  1  synchronous abort: count to 00:00, state IDLE
load  in  1  load ld_min/ld_sec into the count
ld_min  in  7  minutes load value
ld_sec  in  7  seconds load value
start  in  1  begin or resume counting
pause  in  1  suspend counting
min_out  out  7  current minutes, registered
sec_out  out  7  current seconds, registered
running  out  1  high while state is RUN
done  out  1  high while state is EXPIRED
expire  out  1  one-cycle pulse when count reaches 00:00

Behaviour:
- Reset: min_out=0, sec_out=0, state IDLE, running=0, done=0, expire=0.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs registered; running/done decode state.
- Input priority per cycle: rst > clr > load > start/pause > tick.
- clr, any state:
  - count becomes 00:00, state IDLE, expire=0 on the next cycle.
- load, in IDLE, PAUSED or EXPIRED:
  - count <= clamped load value; state IDLE; done clears.
  - Clamp: ld_sec>=SEC_N gives SEC_N-1; ld_min>=MIN_N gives MIN_N-1.
- load in RUN is ignored.
- start:
  - IDLE or PAUSED with nonzero count: go to RUN.
  - Zero count: ignored.
  - RUN or EXPIRED: ignored.
- pause:
  - RUN: go to PAUSED; a tick in the same cycle is discarded.
  - Other states: ignored.
- start and pause together:
  - RUN: treated as pause.
  - PAUSED: treated as start.
- tick in RUN, no higher-priority input:
  - sec>0: sec-1.
  - sec==0 and min>0: sec=SEC_N-1, min-1 (borrow).
- Expiry, tick taking the count to 00:00:
  - Next cycle: count shows 00:00, state EXPIRED, expire=1 for exactly one cycle, done=1.
  - Latency from tick edge to expire: 1 clk.
- tick outside RUN is ignored; the count holds.
- EXPIRED holds 00:00 with done=1 until load or clr; start is ignored.
- expire is 0 in every cycle except the expiry cycle.
- Width rules:
  - Decrement arithmetic is 7-bit and never underflows; 00:00 is not decremented.
  - Values above modulus-1 never appear on the outputs.

Optional Feature:
- Macro: CT_DOWN_TIMER_AUTO_RELOAD_EN.
- Defined:
  - A 14-bit reload register captures the clamped value on every accepted load.
  - The tick that would reach 00:00 instead loads the reload value and stays in RUN.
  - expire still pulses for one cycle, aligned with the reloaded count; done never asserts.
  - The resulting period is the loaded value in ticks; e.g. load 00:01 gives expire every tick.
  - clr also clears the reload register.
- Not defined:
  - No reload register.
  - Expiry enters EXPIRED as described under Behaviour.

Test Plan:
- Reset, then load 01:02, start, 3 ticks -> sequence 01:01, 01:00, 00:59 (borrow); running=1, done=0.
- Load 00:02, start, 2 ticks -> 00:01, then 00:00 with expire=1 for one cycle one clk after the 2nd tick; done=1 held; further ticks leave 00:00, expire=0.
- Load 00:05, start, pause asserted in the same cycle as a tick -> count stays 00:05, state PAUSED; start -> RUN; next tick -> 00:04.
- Load ld_min=99, ld_sec=75 -> 59:59. Load in RUN ignored. clr mid-RUN at 10:30 -> 00:00, IDLE, no expire. Start at 00:00 -> stays IDLE.
- rst asserted mid-RUN at 00:03 with a tick in the same cycle -> 00:00, all flags 0, no expire pulse.
- With CT_DOWN_TIMER_AUTO_RELOAD_EN: load 00:03, start, 7 ticks -> 02, 01, 03 (expire), 02, 01, 03 (expire), 02; done stays 0 throughout.
